// File: rtl/c1_cfg_pkg.sv
// c1_cfg_pkg
// Shared definitions for the c1 select loader: FSM state encoding, the number
// of configuration bits per c1 cell, and the position of each select inside a
// cell's 4-bit group.
package c1_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_PARITY = 2'd2,
      ST_COMMIT = 2'd3
   } cfg_state_e;

   localparam int CELL_CFG_BITS = 4;

   // Bit offsets within one cell's group, also the order bits arrive in.
   localparam int S0_IDX = 0;
   localparam int S1_IDX = 1;
   localparam int SA_IDX = 2;
   localparam int SB_IDX = 3;

endpackage

// File: rtl/c1_cfg_shift.sv
// c1_cfg_shift
// Shadow register and running even-parity accumulator for the c1 loader.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   clr_i      : restart a frame (clears the parity accumulator only; the
//                shadow is overwritten bit by bit as the new frame arrives)
//   wr_i       : write bit_i into shadow[idx_i] and fold it into the parity
//   idx_i      : shadow bit index of the current data bit
//   bit_i      : serial data bit
//   shadow_o   : assembled configuration, not yet visible to the fabric
//   par_o      : XOR of all data bits written since the last clear
module c1_cfg_shift
   import c1_cfg_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic             bit_i,
   output logic [NBITS-1:0] shadow_o,
   output logic             par_o
);

   logic [NBITS-1:0] shadow_q, shadow_d;
   logic             par_q, par_d;

   always_comb begin
      shadow_d = shadow_q;
      par_d    = par_q;
      if (clr_i) begin
         par_d = 1'b0;
      end else if (wr_i) begin
         par_d = par_q ^ bit_i;
         for (int i = 0; i < NBITS; i++) begin
            if (idx_i == IDX_W'(i)) shadow_d[i] = bit_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         par_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         par_q    <= par_d;
      end
   end

   assign shadow_o = shadow_q;
   assign par_o    = par_q;

endmodule

// File: rtl/c1_cfg_loader.sv
// c1_cfg_loader
// Serial writer for the c1 select interface. A frame is a cfg_start strobe,
// NUM_CELLS*4 data bits (cell 0 first, S0/S1/SA/SB within a cell) and one
// even-parity bit. The frame is assembled in a shadow register and copied to
// the active selects only after the parity check passes, so the fabric never
// sees a partial configuration.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   cfg_start             : frame start (restarts a frame in LOAD/PARITY)
//   cfg_valid, cfg_bit    : serial data, accepted when cfg_valid & cfg_ready
//   cfg_ready             : high in LOAD and PARITY
//   busy                  : frame in progress
//   sel_s0/s1/sa/sb       : active selects, one bit per cell
//   cfg_done / cfg_err    : one-cycle registered commit / reject pulses
//
// state     | meaning
// ST_IDLE   | waiting for cfg_start
// ST_LOAD   | accepting data bits into the shadow register
// ST_PARITY | accepting the parity bit and checking it
// ST_COMMIT | copying shadow to the active selects
module c1_cfg_loader
   import c1_cfg_pkg::*;
#(
   parameter int NUM_CELLS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   input  logic                 cfg_bit,
   output logic                 cfg_ready,
   output logic                 busy,
   output logic [NUM_CELLS-1:0] sel_s0,
   output logic [NUM_CELLS-1:0] sel_s1,
   output logic [NUM_CELLS-1:0] sel_sa,
   output logic [NUM_CELLS-1:0] sel_sb,
   output logic                 cfg_done,
   output logic                 cfg_err
);

   localparam int NBITS = NUM_CELLS * CELL_CFG_BITS;
   localparam int CNT_W = $clog2(NBITS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBITS - 1);

   cfg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NBITS-1:0] sel_q, sel_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             sh_clr, sh_wr, sh_par;
   logic [NBITS-1:0] sh_shadow;

   c1_cfg_shift #(
      .NBITS (NBITS),
      .IDX_W (CNT_W)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (sh_clr),
      .wr_i     (sh_wr),
      .idx_i    (cnt_q),
      .bit_i    (cfg_bit),
      .shadow_o (sh_shadow),
      .par_o    (sh_par)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      sh_clr  = 1'b0;
      sh_wr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               sh_clr  = 1'b1;
            end
         end
         ST_LOAD: begin
            // A start strobe wins over a coincident data bit.
            if (cfg_start) begin
               cnt_d  = '0;
               sh_clr = 1'b1;
            end else if (cfg_valid) begin
               sh_wr = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IDX) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               sh_clr  = 1'b1;
            end else if (cfg_valid) begin
               if (cfg_bit == sh_par) begin
                  state_d = ST_COMMIT;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            sel_d   = sh_shadow;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Unpack the committed configuration into per-select buses.
   always_comb begin
      sel_s0 = '0;
      sel_s1 = '0;
      sel_sa = '0;
      sel_sb = '0;
      for (int c = 0; c < NUM_CELLS; c++) begin
         sel_s0[c] = sel_q[c*CELL_CFG_BITS + S0_IDX];
         sel_s1[c] = sel_q[c*CELL_CFG_BITS + S1_IDX];
         sel_sa[c] = sel_q[c*CELL_CFG_BITS + SA_IDX];
         sel_sb[c] = sel_q[c*CELL_CFG_BITS + SB_IDX];
      end
   end

   assign cfg_ready = (state_q == ST_LOAD) || (state_q == ST_PARITY);
   assign busy      = (state_q != ST_IDLE);
   assign cfg_done  = done_q;
   assign cfg_err   = err_q;

endmodule
